// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: op codes and FSM state encoding shared by alu_seq and muldiv_iter.
// Op codes 0-13 keep the single-cycle ALU meanings; 14-19 add mul/div and HI/LO moves.
// Codes 20-31 are reserved and produce a zero result with all flags clear.
package alu_seq_pkg;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_AND  = 5'd2;
    localparam logic [4:0] OP_OR   = 5'd3;
    localparam logic [4:0] OP_NOR  = 5'd4;
    localparam logic [4:0] OP_SRL  = 5'd5;
    localparam logic [4:0] OP_SLT  = 5'd6;
    localparam logic [4:0] OP_SGTU = 5'd7;
    localparam logic [4:0] OP_XOR  = 5'd8;
    localparam logic [4:0] OP_SRA  = 5'd9;
    localparam logic [4:0] OP_BGTZ = 5'd10;
    localparam logic [4:0] OP_BLEZ = 5'd11;
    localparam logic [4:0] OP_BNE  = 5'd12;
    localparam logic [4:0] OP_SLL  = 5'd13;
    localparam logic [4:0] OP_MULT = 5'd14;
    localparam logic [4:0] OP_DIV  = 5'd15;
    localparam logic [4:0] OP_MFHI = 5'd16;
    localparam logic [4:0] OP_MFLO = 5'd17;
    localparam logic [4:0] OP_MTHI = 5'd18;
    localparam logic [4:0] OP_MTLO = 5'd19;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative shift-add multiplier / restoring divider sharing one W-bit datapath.
// Latency WIDTH+2 edges counting the start edge (2 for divide-by-zero); done pulses in the FIX cycle.
// No backpressure: busy is high from the start edge until done; flush aborts RUN/FIX to IDLE.
// Ports: start/is_div/signctl/a/b capture an op in IDLE; hi_res/lo_res/div0/ovf are valid while done.
module muldiv_iter
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic             signctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_res,
    output logic [WIDTH-1:0] lo_res,
    output logic             div0,
    output logic             ovf
);

    localparam int SHW = $clog2(WIDTH);

    state_t            state, state_nxt;
    logic [SHW-1:0]    cnt;
    // hacc/lacc: product high/low halves while multiplying, remainder/quotient while dividing
    logic [WIDTH-1:0]  hacc, lacc, opb;
    logic              mode_div, neg_res, neg_rem, dz, ovf_q;
    logic              iter;

    logic [WIDTH-1:0]  a_mag, b_mag;
    logic              a_neg, b_neg, b_zero;

    assign a_neg  = signctl && a[WIDTH-1];
    assign b_neg  = signctl && b[WIDTH-1];
    assign a_mag  = a_neg ? (~a + 1'b1) : a;
    assign b_mag  = b_neg ? (~b + 1'b1) : b;
    assign b_zero = (b == '0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: divide-by-zero skips RUN entirely
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (is_div && b_zero) ? FIX : RUN;
            RUN:  if (flush) state_nxt = IDLE;
                  else if (cnt == SHW'(WIDTH-1)) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state != IDLE);
        done = (state == FIX) && !flush;
        iter = (state == RUN) && !flush;
    end

    // One iteration of each algorithm
    logic [WIDTH:0] madd, dshift, ddiff;
    logic           ge;
    assign madd   = {1'b0, hacc} + (lacc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
    assign dshift = {hacc, lacc[WIDTH-1]};
    assign ddiff  = dshift - {1'b0, opb};
    assign ge     = (dshift >= {1'b0, opb});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            hacc     <= '0;
            lacc     <= '0;
            opb      <= '0;
            mode_div <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            dz       <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (start && state == IDLE) begin
            cnt      <= '0;
            mode_div <= is_div;
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            dz       <= is_div && b_zero;
            // Only signed most-negative / -1 overflows; the magnitude path still yields the right bits
            ovf_q    <= is_div && signctl && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
            opb      <= b_mag;
            if (is_div && b_zero) begin
                hacc <= a;
                lacc <= '1;
            end else if (is_div) begin
                hacc <= '0;
                lacc <= a_mag;
            end else begin
                hacc <= '0;
                lacc <= b_mag;
                opb  <= a_mag;
            end
        end else if (iter) begin
            cnt <= cnt + 1'b1;
            if (mode_div) begin
                hacc <= ge ? ddiff[WIDTH-1:0] : dshift[WIDTH-1:0];
                lacc <= {lacc[WIDTH-2:0], ge};
            end else begin
                hacc <= madd[WIDTH:1];
                lacc <= {madd[0], lacc[WIDTH-1:1]};
            end
        end
    end

    // Sign correction applied combinationally during FIX
    logic [2*WIDTH-1:0] prod, prod_fix;
    assign prod     = {hacc, lacc};
    assign prod_fix = neg_res ? (~prod + 1'b1) : prod;

    always_comb begin
        hi_res = prod_fix[2*WIDTH-1:WIDTH];
        lo_res = prod_fix[WIDTH-1:0];
        if (dz) begin
            hi_res = hacc;
            lo_res = lacc;
        end else if (mode_div) begin
            hi_res = neg_rem ? (~hacc + 1'b1) : hacc;
            lo_res = neg_res ? (~lacc + 1'b1) : lacc;
        end
    end

    assign div0 = dz;
    assign ovf  = ovf_q;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered execute-stage ALU with iterative mul/div and HI/LO registers.
// Latency 1 for ops 0-13 and 16-31; WIDTH+2 edges for mult/div (2 for divide by zero).
// in_ready drops while mul/div runs; flush aborts in-flight work and blocks same-edge acceptance.
// Ports: in_valid/in_ready handshake with op/signctl/a/b/shamt; out_valid pulses with result/zero/ovf/div0.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic             signctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic             accept, is_md, md_busy, md_done, md_div0, md_ovf;
    logic [WIDTH-1:0] md_hi, md_lo;

    assign in_ready = !md_busy;
    assign accept   = in_valid && in_ready && !flush;
    assign is_md    = (op == OP_MULT) || (op == OP_DIV);

    muldiv_iter #(.WIDTH(WIDTH)) u_md (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && is_md),
        .is_div  (op == OP_DIV),
        .signctl (signctl),
        .a       (a),
        .b       (b),
        .flush   (flush),
        .busy    (md_busy),
        .done    (md_done),
        .hi_res  (md_hi),
        .lo_res  (md_lo),
        .div0    (md_div0),
        .ovf     (md_ovf)
    );

    // Single-cycle ops
    logic [WIDTH:0]   sum_ext, diff_ext;
    logic [WIDTH-1:0] alu_res;
    logic             alu_zero, alu_ovf, lt;

    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};
    assign lt       = signctl ? ($signed(a) < $signed(b)) : (a < b);

    always_comb begin
        alu_res  = '0;
        alu_zero = 1'b0;
        alu_ovf  = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum_ext[WIDTH-1:0];
                alu_ovf = signctl ? ((a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]))
                                  : sum_ext[WIDTH];
            end
            OP_SUB: begin
                alu_res  = diff_ext[WIDTH-1:0];
                alu_zero = (diff_ext[WIDTH-1:0] == '0);
                // diff_ext[WIDTH] is the unsigned borrow
                alu_ovf  = signctl ? ((a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]))
                                   : diff_ext[WIDTH];
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_NOR:  alu_res = ~(a | b);
            OP_SRL:  alu_res = b >> shamt;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, lt};
            OP_SGTU: alu_res = {{(WIDTH-1){1'b0}}, (a > b)};
            OP_XOR:  alu_res = a ^ b;
            OP_SRA:  alu_res = WIDTH'($signed(b) >>> shamt);
            OP_BGTZ: alu_zero = !a[WIDTH-1] && (a != '0);
            OP_BLEZ: alu_zero = a[WIDTH-1] || (a == '0);
            OP_BNE:  alu_zero = (a != b);
            OP_SLL:  alu_res = b << shamt;
            OP_MFHI: alu_res = hi;
            OP_MFLO: alu_res = lo;
            OP_MTHI: alu_res = a;
            OP_MTLO: alu_res = a;
            default: ;
        endcase
    end

    // Output and HI/LO registers; result/flags hold between out_valid pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
            div0      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            out_valid <= 1'b0;
            if (md_done) begin
                out_valid <= 1'b1;
                result    <= md_lo;
                zero      <= 1'b0;
                ovf       <= md_ovf;
                div0      <= md_div0;
                hi        <= md_hi;
                lo        <= md_lo;
            end else if (accept && !is_md) begin
                out_valid <= 1'b1;
                result    <= alu_res;
                zero      <= alu_zero;
                ovf       <= alu_ovf;
                div0      <= 1'b0;
                if (op == OP_MTHI) hi <= a;
                if (op == OP_MTLO) lo <= a;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        rst_n, in_valid, signctl, flush;
    logic        in_ready, out_valid, zero, ovf, div0;
    logic [4:0]  op, shamt;
    logic [31:0] a, b, result, hi, lo;

    alu_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .signctl(signctl), .a(a), .b(b), .shamt(shamt), .flush(flush),
        .out_valid(out_valid), .result(result), .zero(zero), .ovf(ovf),
        .div0(div0), .hi(hi), .lo(lo)
    );

    // 8-bit instance
    logic        rst8_n, in_valid8, signctl8, flush8;
    logic        in_ready8, out_valid8, zero8, ovf8, div08;
    logic [4:0]  op8;
    logic [2:0]  shamt8;
    logic [7:0]  a8, b8, result8, hi8, lo8;

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst8_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .op(op8), .signctl(signctl8), .a(a8), .b(b8), .shamt(shamt8), .flush(flush8),
        .out_valid(out_valid8), .result(result8), .zero(zero8), .ovf(ovf8),
        .div0(div08), .hi(hi8), .lo(lo8)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [4:0] o, input logic sc, input logic [31:0] aa,
                         input logic [31:0] bb, input logic [4:0] sh);
        @(negedge clk);
        op = o; signctl = sc; a = aa; b = bb; shamt = sh; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // n = edges from acceptance (acceptance edge is 1) until out_valid; low = cycles with in_ready=0
    task automatic wait_done(output int n, output int low);
        n = 1; low = 0;
        while (!out_valid && n < 200) begin
            if (!in_ready) low++;
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    typedef struct {
        logic [4:0]  op;
        logic        sc;
        logic [31:0] a, b;
        logic [4:0]  sh;
        logic [31:0] res;
        logic        z, v;
    } vec_t;

    vec_t vq[$];

    task automatic addv(input logic [4:0] o, input logic sc, input logic [31:0] aa, input logic [31:0] bb,
                        input logic [4:0] sh, input logic [31:0] r, input logic z, input logic v);
        vec_t t;
        t.op = o; t.sc = sc; t.a = aa; t.b = bb; t.sh = sh; t.res = r; t.z = z; t.v = v;
        vq.push_back(t);
    endtask

    initial begin
        int n, low, seen;
        rst_n = 1'b0; in_valid = 1'b0; signctl = 1'b0; flush = 1'b0;
        op = '0; a = '0; b = '0; shamt = '0;
        rst8_n = 1'b0; in_valid8 = 1'b0; signctl8 = 1'b0; flush8 = 1'b0;
        op8 = '0; a8 = '0; b8 = '0; shamt8 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1; rst8_n = 1'b1;
        @(posedge clk); #1;

        chk("rst_ready", in_ready, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_flags", {zero, ovf, div0}, 0);

        // op, signctl, a, b, shamt -> result, zero, ovf
        addv(OP_ADD,  0, 32'hFFFF_FFFF, 32'h1,          0,  32'h0,          0, 1);
        addv(OP_ADD,  1, 32'hFFFF_FFFF, 32'h1,          0,  32'h0,          0, 0);
        addv(OP_ADD,  1, 32'h7FFF_FFFF, 32'h1,          0,  32'h8000_0000,  0, 1);
        addv(OP_SUB,  0, 32'd5,         32'd5,          0,  32'h0,          1, 0);
        addv(OP_SUB,  0, 32'd3,         32'd5,          0,  32'hFFFF_FFFE,  0, 1);
        addv(OP_AND,  0, 32'hF0F0_1234, 32'h0FF0_FFFF,  0,  32'h00F0_1234,  0, 0);
        addv(OP_NOR,  0, 32'h0,         32'h0,          0,  32'hFFFF_FFFF,  0, 0);
        addv(OP_SRA,  0, 32'h0,         32'h8000_0010,  4,  32'hF800_0001,  0, 0);
        addv(OP_SRL,  0, 32'h0,         32'h8000_0010,  4,  32'h0800_0001,  0, 0);
        addv(OP_SLL,  0, 32'h0,         32'h1,          31, 32'h8000_0000,  0, 0);
        addv(OP_SLT,  1, 32'hFFFF_FFFF, 32'h1,          0,  32'h1,          0, 0);
        addv(OP_SLT,  0, 32'hFFFF_FFFF, 32'h1,          0,  32'h0,          0, 0);
        addv(OP_SGTU, 0, 32'hFFFF_FFFF, 32'h1,          0,  32'h1,          0, 0);
        addv(OP_XOR,  0, 32'h0000_A5A5, 32'h0000_FFFF,  0,  32'h0000_5A5A,  0, 0);
        addv(5'd25,   0, 32'h1234,      32'h5678,       0,  32'h0,          0, 0);
        addv(OP_BGTZ, 0, 32'd5,         32'd0,          0,  32'h0,          1, 0);
        addv(OP_BLEZ, 0, 32'd5,         32'd0,          0,  32'h0,          0, 0);
        addv(OP_BLEZ, 0, 32'h8000_0000, 32'd0,          0,  32'h0,          1, 0);
        addv(OP_BNE,  0, 32'd1,         32'd2,          0,  32'h0,          1, 0);
        addv(OP_MTHI, 0, 32'hA5,        32'd0,          0,  32'hA5,         0, 0);
        addv(OP_MTLO, 0, 32'h5A,        32'd0,          0,  32'h5A,         0, 0);
        addv(OP_MFHI, 0, 32'd0,         32'd0,          0,  32'hA5,         0, 0);

        foreach (vq[i]) begin
            issue(vq[i].op, vq[i].sc, vq[i].a, vq[i].b, vq[i].sh);
            chk($sformatf("v%0d_valid", i), out_valid, 1);
            chk($sformatf("v%0d_result", i), result, vq[i].res);
            chk($sformatf("v%0d_zero", i), zero, vq[i].z);
            chk($sformatf("v%0d_ovf", i), ovf, vq[i].v);
            chk($sformatf("v%0d_ready", i), in_ready, 1);
        end

        // Flush mid-RUN: no out_valid, hi/lo keep the mthi/mtlo values
        issue(OP_MULT, 1, 32'd3, 32'd7, 0);
        chk("fl_busy", in_ready, 0);
        repeat (8) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        chk("fl_ready", in_ready, 1);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("fl_novalid", seen, 0);
        chk("fl_hi", hi, 32'hA5);
        chk("fl_lo", lo, 32'h5A);

        // Flush in IDLE beats in_valid
        @(negedge clk); op = OP_MTHI; a = 32'h77; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0; flush = 1'b0;
        chk("fli_valid", out_valid, 0);
        chk("fli_hi", hi, 32'hA5);

        // Signed multiply -3 * 7
        issue(OP_MULT, 1, 32'hFFFF_FFFD, 32'd7, 0);
        wait_done(n, low);
        chk("mul_lat", n, 34);
        chk("mul_lowrdy", low, 33);
        chk("mul_ready", in_ready, 1);
        chk("mul_hi", hi, 32'hFFFF_FFFF);
        chk("mul_lo", lo, 32'hFFFF_FFEB);
        chk("mul_res", result, 32'hFFFF_FFEB);
        @(posedge clk); #1;
        chk("mul_pulse", out_valid, 0);

        // Signed divide -7 / 2, then mfhi
        issue(OP_DIV, 1, 32'hFFFF_FFF9, 32'd2, 0);
        wait_done(n, low);
        chk("div_lat", n, 34);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        chk("div_div0", div0, 0);
        issue(OP_MFHI, 0, 32'd0, 32'd0, 0);
        chk("mfhi_res", result, 32'hFFFF_FFFF);

        // Unsigned multiply with full-width high half
        issue(OP_MULT, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        wait_done(n, low);
        chk("mulu_hi", hi, 32'hFFFF_FFFE);
        chk("mulu_lo", lo, 32'h0000_0001);

        // Divide by zero
        issue(OP_DIV, 0, 32'h1234, 32'd0, 0);
        wait_done(n, low);
        chk("dz_lat", n, 2);
        chk("dz_div0", div0, 1);
        chk("dz_hi", hi, 32'h1234);
        chk("dz_lo", lo, 32'hFFFF_FFFF);

        // Most-negative / -1
        issue(OP_DIV, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        wait_done(n, low);
        chk("mn_lo", lo, 32'h8000_0000);
        chk("mn_hi", hi, 32'h0);
        chk("mn_ovf", ovf, 1);
        chk("mn_div0", div0, 0);

        // 8-bit instance: 200 / 7 unsigned
        @(negedge clk); op8 = OP_DIV; signctl8 = 1'b0; a8 = 8'd200; b8 = 8'd7; in_valid8 = 1'b1;
        @(posedge clk); #1; in_valid8 = 1'b0;
        n = 1;
        while (!out_valid8 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("w8_lat", n, 10);
        chk("w8_lo", lo8, 8'd28);
        chk("w8_hi", hi8, 8'd4);
        chk("w8_res", result8, 8'd28);

        // Async reset mid-RUN clears everything immediately
        @(negedge clk); op8 = OP_DIV; a8 = 8'd100; b8 = 8'd3; in_valid8 = 1'b1;
        @(posedge clk); #1; in_valid8 = 1'b0;
        repeat (3) @(posedge clk);
        #2; rst8_n = 1'b0;
        #1;
        chk("w8r_result", result8, 0);
        chk("w8r_hilo", {hi8, lo8}, 0);
        chk("w8r_flags", {out_valid8, zero8, ovf8, div08}, 0);
        @(negedge clk); rst8_n = 1'b1;
        @(posedge clk); #1;
        chk("w8r_ready", in_ready8, 1);
        repeat (12) @(posedge clk);
        #1;
        chk("w8r_novalid", out_valid8, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation ran past time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor of the single-cycle datapath ALU.
- Keeps ALU op codes 0-13 with the same meanings, now at latency 1.
- Adds an iterative multiply/divide unit with HI/LO registers and a valid/ready handshake.
- Sits in the execute stage; the pipeline controller stalls on in_ready=0.

Parameters:
- WIDTH, 32, datapath width in bits (≥8, power of 2).
- SHW, $clog2(WIDTH), shift-amount width (localparam, not overridable).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept; an op is accepted when in_valid&&in_ready at a clk edge
- op  in  5  operation code (see Behaviour)
- signctl  in  1  1 = signed semantics for slt/add/sub overflow/mult/div
- a  in  WIDTH  operand A (rs)
- b  in  WIDTH  operand B (rt)
- shamt  in  SHW  shift amount
- flush  in  1  synchronous abort of any in-flight op
- out_valid  out  1  one-cycle pulse: result/flags valid
- result  out  WIDTH  op result
- zero  out  1  branch condition
- ovf  out  1  overflow/carry flag
- div0  out  1  divide-by-zero flag
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=1 after release; out_valid, result, zero, ovf, div0, hi, lo, counter = 0.
- Ops 0-13:
  - 0 add, 1 sub, 2 and, 3 or, 4 nor, 5 srl, 6 slt, 7 sgt-unsigned, 8 xor, 9 sra, 10 bgtz, 11 blez, 12 bne, 13 sll.
  - Sub sets zero when result==0. Codes 10/11/12 set only zero; result=0.
  - sra is arithmetic on b: sign bit replicated.
  - add/sub ovf: signctl=0 gives carry-out (add) or borrow (sub); signctl=1 gives signed overflow.
  - Latency 1: out_valid=1 on the edge after acceptance; in_ready stays 1.
- New ops:
  - 14 mult: signctl chooses mult vs multu.
  - 15 div: signctl chooses div vs divu.
  - 16 mfhi, 17 mflo: result=hi/lo, latency 1.
  - 18 mthi, 19 mtlo: hi/lo←a, latency 1, result=a.
  - Codes 20-31: result=0, flags 0, latency 1.
- FSM states: IDLE, RUN, FIX.
  - IDLE→RUN on accepting 14/15. Operand magnitudes are captured (abs if signctl); counter=0; in_ready=0.
  - RUN runs one iteration per cycle; after iteration WIDTH-1 → FIX.
    - Multiply: shift-add.
    - Divide: restoring, one quotient bit per cycle.
  - FIX (1 cycle) applies sign correction:
    - Product negated if signs differ.
    - Quotient negated if signs differ; remainder takes the dividend's sign.
    - Writes hi = product[2W-1:W] / remainder and lo = product[W-1:0] / quotient.
    - Pulses out_valid with result=lo. → IDLE.
  - Total latency WIDTH+2 edges from acceptance to out_valid; in_ready returns 1 in the out_valid cycle.
- Divide by zero (b==0):
  - Skips RUN; FIX next cycle.
  - hi=a, lo=all ones, div0=1.
  - Latency 2.
- Signed edge case: most-negative / −1 gives lo=most-negative, hi=0, ovf=1.
- mfhi/mflo during RUN cannot be accepted (in_ready=0). Back-to-back mult then mfhi returns the new hi.
- Flush:
  - In RUN/FIX: → IDLE next edge; no out_valid; hi/lo unchanged.
  - In IDLE with in_valid: the op is not accepted.
  - Flush beats in_valid on the same edge.
- Outputs result/zero/ovf/div0 hold their last value between pulses; only out_valid qualifies them.
- Async reset mid-RUN: immediate IDLE; hi/lo cleared.

Decomposition:
- Package alu_seq_pkg:
  - Op-code localparams OP_ADD..OP_MTLO.
  - State enum IDLE/RUN/FIX.
- Sub-module muldiv_iter holds the shared W-bit iterative shift-add/restore-subtract datapath, counter and sign-fix logic.
- alu_seq holds the single-cycle ops, HI/LO and the handshake.

Test Plan:
- Op 0, a=0xFFFFFFFF, b=1, signctl=0 -> next edge result=0, ovf=1; signctl=1 -> ovf=0. Op 1, a=b=5 -> zero=1.
- Op 14, signctl=1, a=-3, b=7 -> in_ready low 33 cycles; out_valid at edge 34, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- Op 15, signctl=1, a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); then op 16 -> result=0xFFFFFFFF.
- Op 15, b=0, a=0x1234 -> out_valid 2 edges later, div0=1, hi=0x1234, lo=0xFFFFFFFF.
- Op 14 accepted, flush at cycle 10 -> no out_valid; hi/lo keep the prior mthi/mtlo values 0xA5/0x5A; in_ready=1 next cycle.
- WIDTH=8 build, op 15 unsigned a=200, b=7 -> lo=28, hi=4 after 10 edges; rst_n low mid-RUN -> all outputs 0 immediately.
